// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary-to-BCD converter (shift-add-3, one bit per clock)
module bin2bcd_seq #(
    parameter int IN_WIDTH = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] bin,
    output logic                busy,
    output logic                done,
    output logic [15:0]         bcd_out,
    output logic                overflow
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [IN_WIDTH-1:0] SAT_VAL = IN_WIDTH'(14'd9999);

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   shreg_q, shreg_d;
    logic [15:0]           acc_q, acc_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  ovf_pend_q, ovf_pend_d;
    logic                  done_q, done_d;
    logic [15:0]           bcd_q, bcd_d;
    logic                  overflow_q, overflow_d;

    logic [31:0]           bin_ext;
    logic                  saturate;
    logic [15:0]           acc_corr;
    logic [15:0]           acc_shift;

    // Widening first keeps the compare legal for every IN_WIDTH; it folds to false below 14 bits.
    assign bin_ext  = 32'(bin);
    assign saturate = (bin_ext > 32'd9999);

    always_comb begin
        acc_corr = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) begin
                acc_corr[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
            end
        end
        acc_shift = {acc_corr[14:0], shreg_q[IN_WIDTH-1]};
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d    = saturate ? SAT_VAL : bin;
                    ovf_pend_d = saturate;
                    acc_d      = 16'h0000;
                    cnt_d      = 4'(IN_WIDTH);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = acc_shift;
                shreg_d = {shreg_q[IN_WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q - 4'd1;
                // Results publish only on the last shift so the display never sees partial digits.
                if (cnt_q == 4'd1) begin
                    bcd_d      = acc_shift;
                    overflow_d = ovf_pend_q;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            acc_q      <= 16'h0000;
            cnt_q      <= 4'd0;
            ovf_pend_q <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= 16'h0000;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed table-driven bench for bin2bcd_seq
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    int checks;
    int passed;
    logic [15:0] exp_prev;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[11];

    bin2bcd_seq #(.IN_WIDTH(14)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Start a conversion, then follow it edge by edge to the done pulse.
    task automatic run_conv(input logic [13:0] b, input logic [15:0] eb, input logic eo);
        int lat;
        lat = 0;
        @(negedge clk);
        bin   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = 14'h3fff;
        chk("busy_after_start", busy, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 13) chk("hold_old_bcd", bcd_out, exp_prev);
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, 14);
        chk("bcd", bcd_out, eb);
        chk("ovf", overflow, eo);
        chk("busy_at_done", busy, 1'b0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 1'b0);
        exp_prev = eb;
    endtask

    initial begin
        int ndone;
        int lat;
        checks   = 0;
        passed   = 0;
        exp_prev = 16'h0000;
        vecs[0]  = '{14'd0,     16'h0000, 1'b0};
        vecs[1]  = '{14'd1234,  16'h1234, 1'b0};
        vecs[2]  = '{14'd9999,  16'h9999, 1'b0};
        vecs[3]  = '{14'd10000, 16'h9999, 1'b1};
        vecs[4]  = '{14'd16383, 16'h9999, 1'b1};
        vecs[5]  = '{14'd5,     16'h0005, 1'b0};
        vecs[6]  = '{14'd10,    16'h0010, 1'b0};
        vecs[7]  = '{14'd99,    16'h0099, 1'b0};
        vecs[8]  = '{14'd100,   16'h0100, 1'b0};
        vecs[9]  = '{14'd8191,  16'h8191, 1'b0};
        vecs[10] = '{14'd4096,  16'h4096, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        bin   = 14'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_bcd", bcd_out, 16'h0000);
        chk("rst_ovf", overflow, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", busy, 1'b0);

        for (int i = 0; i < 11; i++) begin
            run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
        end

        // A start while busy must be dropped, not queued.
        @(negedge clk);
        bin   = 14'd42;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bin   = 14'd77;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        lat   = 0;
        for (int k = 6; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (lat == 0) lat = k;
            end
        end
        chk("ign_done_count", ndone, 1);
        chk("ign_latency", lat, 14);
        chk("ign_bcd", bcd_out, 16'h0042);
        chk("ign_ovf", overflow, 1'b0);
        exp_prev = 16'h0042;

        // Back-to-back: the second start lands in the done cycle.
        run_conv(14'd5678, 16'h5678, 1'b0);
        @(negedge clk);
        bin   = 14'd1111;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("pre_b2b_bcd", bcd_out, 16'h1111);
        bin   = 14'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_done_low", done, 1'b0);
        chk("b2b_first_held", bcd_out, 16'h1111);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("b2b_latency", lat, 14);
        chk("b2b_bcd", bcd_out, 16'h0009);

        // Asynchronous reset mid-conversion.
        @(negedge clk);
        bin   = 14'd8888;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_bcd", bcd_out, 16'h0000);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_ovf", overflow, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("arst_no_done", ndone, 0);
        exp_prev = 16'h0000;
        run_conv(14'd321, 16'h0321, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
